// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: ALU op/sel codes and divider states.
package ex_stage_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic [7:0] EXE_OR_OP   = 8'h25;
    localparam logic [7:0] EXE_AND_OP  = 8'h24;
    localparam logic [7:0] EXE_XOR_OP  = 8'h26;
    localparam logic [7:0] EXE_NOR_OP  = 8'h27;
    localparam logic [7:0] EXE_SLL_OP  = 8'h7C;
    localparam logic [7:0] EXE_SRL_OP  = 8'h02;
    localparam logic [7:0] EXE_SRA_OP  = 8'h03;
    localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP = 8'h1B;
    localparam logic [7:0] EXE_MFHI_OP = 8'h10;
    localparam logic [7:0] EXE_MFLO_OP = 8'h12;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivBusy = 2'd1,
        DivDone = 2'd2
    } div_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// id_ex bundle into the execute stage and its registered results.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic                flush_i;
    logic [ALUOP_W-1:0]  aluop_i;
    logic [ALUSEL_W-1:0] alusel_i;
    logic [31:0]         reg1_i;
    logic [31:0]         reg2_i;
    logic [4:0]          wd_i;
    logic                wreg_i;
    logic [4:0]          wd_o;
    logic                wreg_o;
    logic [31:0]         wdata_o;
    logic [31:0]         hi_o;
    logic [31:0]         lo_o;
    logic                stallreq_o;

    modport master (
        output flush_i, aluop_i, alusel_i,
        output reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o,
        input  hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  flush_i, aluop_i, alusel_i,
        input  reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o,
        output hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_stage_div.sv
// Iterative restoring divider: one quotient bit per cycle, signed fix-up on output.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        stall
);

    localparam logic [4:0] LAST = 5'(DIV_CYCLES - 1);

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic        a_neg;
    logic        b_neg;
    logic [32:0] trial;
    logic [32:0] diff;

    assign a_neg = sgn & dividend[31];
    assign b_neg = sgn & divisor[31];
    assign trial = {rem, quo[31]};
    // Borrow out of the 33-bit subtract means trial < divisor.
    assign diff  = trial - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DivIdle;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else if (abort) begin
            state <= DivIdle;
        end else begin
            case (state)
                DivIdle: begin
                    if (start) begin
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= a_neg ? -dividend : dividend;
                        dsr   <= b_neg ? -divisor : divisor;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dz    <= (divisor == '0);
                        state <= (divisor == '0) ? DivDone : DivBusy;
                    end
                end
                DivBusy: begin
                    if (diff[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end else begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) state <= DivDone;
                end
                DivDone: state <= DivIdle;
                default: state <= DivIdle;
            endcase
        end
    end

    assign done      = (state == DivDone) && !dz && !abort;
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;
    assign stall     = !rst && !abort &&
                       ((state == DivIdle && start) || state == DivBusy);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move with 1-cycle registered output, DIV/DIVU, HI/LO.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    logic        is_div;
    logic        div_done;
    logic        div_stall;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] r1;
    logic [31:0] r2;

    assign r1     = bus.reg1_i;
    assign r2     = bus.reg2_i;
    assign is_div = (bus.aluop_i == EXE_DIV_OP) ||
                    (bus.aluop_i == EXE_DIVU_OP);

    div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .sgn       (bus.aluop_i == EXE_DIV_OP),
        .abort     (bus.flush_i),
        .dividend  (r1),
        .divisor   (r2),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r),
        .stall     (div_stall)
    );

    always_comb begin
        result = '0;
        case (bus.alusel_i)
            EXE_RES_LOGIC: begin
                case (bus.aluop_i)
                    EXE_OR_OP:  result = r1 | r2;
                    EXE_AND_OP: result = r1 & r2;
                    EXE_XOR_OP: result = r1 ^ r2;
                    EXE_NOR_OP: result = ~(r1 | r2);
                    default:    result = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (bus.aluop_i)
                    EXE_SLL_OP: result = r2 << r1[4:0];
                    EXE_SRL_OP: result = r2 >> r1[4:0];
                    EXE_SRA_OP: result = $signed(r2) >>> r1[4:0];
                    default:    result = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (bus.aluop_i)
                    EXE_MFHI_OP: result = hi;
                    EXE_MFLO_OP: result = lo;
                    default:     result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wd_o    <= '0;
            bus.wreg_o  <= 1'b0;
            bus.wdata_o <= '0;
            hi          <= '0;
            lo          <= '0;
        end else if (bus.flush_i) begin
            bus.wd_o    <= '0;
            bus.wreg_o  <= 1'b0;
            bus.wdata_o <= '0;
        end else begin
            bus.wd_o <= bus.wd_i;
            // A divide, including its DONE cycle, emits a bubble.
            if (div_stall || is_div) begin
                bus.wreg_o  <= 1'b0;
                bus.wdata_o <= '0;
            end else begin
                bus.wreg_o  <= bus.wreg_i;
                bus.wdata_o <= result;
            end
            if (div_done) begin
                hi <= div_r;
                lo <= div_q;
            end
        end
    end

    assign bus.hi_o       = hi;
    assign bus.lo_o       = lo;
    assign bus.stallreq_o = div_stall;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, downstream of the decode stage's aluop/alusel/operand/destination bundle (via the id_ex latch).
- Computes logic, shift and move results with a registered 1-cycle output.
- Runs DIV/DIVU on an iterative 32-cycle divider FSM that stalls upstream.
- Owns the HI/LO registers.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles (one quotient bit per cycle); fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  abort the in-flight operation; output a bubble
- aluop_i  in  8  operation code (AluOpBus)
- alusel_i  in  3  result class (AluSelBus)
- reg1_i  in  32  operand 1 (register value or immediate)
- reg2_i  in  32  operand 2
- wd_i  in  5  destination GPR address
- wreg_i  in  1  GPR write enable
- wd_o  out  5  registered destination address
- wreg_o  out  1  registered write enable
- wdata_o  out  32  registered result
- hi_o  out  32  HI register
- lo_o  out  32  LO register
- stallreq_o  out  1  combinational; upstream holds inputs stable while high

Behaviour:
- Reset (rst=1 at clk edge):
  - wd_o=0, wreg_o=0, wdata_o=0, hi_o=0, lo_o=0.
  - FSM returns to IDLE; divider datapath is cleared.
  - stallreq_o=0 while rst is high.
- Single-cycle ops (alusel LOGIC=001, SHIFT=010, MOVE=011), latency 1: result, wd_i and wreg_i appear on the outputs after the next edge.
  - LOGIC: OR, AND, XOR, NOR of reg1_i and reg2_i.
  - SHIFT: SLL/SRL/SRA shift reg2_i by reg1_i[4:0]. SRA is arithmetic.
  - MOVE: MFHI gives hi_o; MFLO gives lo_o.
- Unrecognised aluop, or alusel NOP: wdata_o=0 and wreg_o=wreg_i.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with DIV/DIVU and reg2_i!=0:
    - Latch |dividend| and |divisor| (raw values for DIVU), plus the sign flags.
    - stallreq_o=1; next state BUSY.
    - Counter starts at 0.
  - IDLE with DIV/DIVU and reg2_i==0:
    - stallreq_o=1 for this cycle; next state DONE.
    - HI/LO stay unchanged.
  - BUSY: one restoring-division step per cycle; stallreq_o=1.
    - Counter reaches DIV_CYCLES-1, then go to DONE.
  - DONE: stallreq_o=0.
    - At the edge: LO<=quotient, HI<=remainder, then IDLE.
    - The current inputs are still the completing DIV. They must not restart the divider.
- Signed fix-up (DIV):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- stallreq_o timing for DIV: high for 33 consecutive cycles (1 IDLE + 32 BUSY), low in DONE.
- Output registers during any stall cycle, and in DONE: wreg_o=0, wdata_o=0. DIV never writes a GPR.
- flush_i=1 at an edge, in any state:
  - FSM goes to IDLE, wreg_o=0, wdata_o=0.
  - HI/LO are not updated.
  - stallreq_o=0 in the cycle flush_i is high.
- rst takes priority over flush_i; flush_i takes priority over completion.
- MFHI/MFLO in the cycle after DONE reads the updated HI/LO. Completion and a read never coincide, so no bypass is required.

Decomposition:
- Shared defines package (extends the existing defines include):
  - AluOpBus=7:0, AluSelBus=2:0.
  - EXE_OR_OP 8'h25, EXE_AND_OP 8'h24, EXE_XOR_OP 8'h26, EXE_NOR_OP 8'h27.
  - EXE_SLL_OP 8'h7C, EXE_SRL_OP 8'h02, EXE_SRA_OP 8'h03.
  - EXE_DIV_OP 8'h1A, EXE_DIVU_OP 8'h1B, EXE_MFHI_OP 8'h10, EXE_MFLO_OP 8'h12.
  - EXE_RES_LOGIC 3'b001, EXE_RES_SHIFT 3'b010, EXE_RES_MOVE 3'b011.
  - DivIdle/DivBusy/DivDone state encodings.
- Sub-module div_iter: divider FSM plus datapath, with start, signed, abort inputs and done, quotient, remainder, stall outputs.
- ex_stage instantiates div_iter and owns HI/LO and the output registers.

Test Plan:
- OR: reg1=0x00001100, reg2=0x00000020, wd=5, wreg=1 -> next cycle wd_o=5, wreg_o=1, wdata_o=0x00001120, stallreq_o=0.
- SRA: reg1=4, reg2=0x80000000 -> wdata_o=0xF8000000. SRL with the same operands -> 0x08000000.
- DIVU 100/7, inputs held while stalled:
  - stallreq_o high exactly 33 cycles, wreg_o=0 throughout.
  - After DONE: lo_o=14, hi_o=2.
  - A following MFLO with wd=3 -> wdata_o=14.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV with HI/LO preloaded to 2/14 and reg2=0 -> stallreq_o high 1 cycle, then hi_o=2, lo_o=14 unchanged.
- DIVU 100/7 with flush_i pulsed on BUSY cycle 10:
  - stallreq_o=0 from that cycle; HI/LO unchanged.
  - Next OR executes with 1-cycle latency.
- Repeat that DIVU with rst on BUSY cycle 10 instead of flush_i -> all outputs 0, FSM idle.
